// File: rtl/dcache_responder_if.sv
// dcache_responder_if: request-unit cache handshake plus backing-RAM port.
// slave  = the responder (dcache_responder)
// master = the environment that issues requests and models the RAM
interface dcache_responder_if;
    logic        imemREN;
    logic [31:0] imemaddr;
    logic        ihit;
    logic [31:0] imemload;
    logic        dmemREN;
    logic        dmemWEN;
    logic        datomic;
    logic [31:0] dmemaddr;
    logic [31:0] dmemstore;
    logic        dhit;
    logic [31:0] dmemload;
    logic        ramREN;
    logic        ramWEN;
    logic [31:0] ramaddr;
    logic [31:0] ramstore;
    logic [31:0] ramload;
    logic        ramready;

    modport slave (
        input  imemREN, imemaddr, dmemREN, dmemWEN, datomic, dmemaddr, dmemstore,
        input  ramload, ramready,
        output ihit, imemload, dhit, dmemload,
        output ramREN, ramWEN, ramaddr, ramstore
    );

    modport master (
        output imemREN, imemaddr, dmemREN, dmemWEN, datomic, dmemaddr, dmemstore,
        output ramload, ramready,
        input  ihit, imemload, dhit, dmemload,
        input  ramREN, ramWEN, ramaddr, ramstore
    );
endinterface

// File: rtl/dcache_responder.sv
// dcache_responder: arbitrates instruction fetches and data reads/writes onto
// a single-port RAM and returns one-cycle ihit/dhit pulses with registered data.
// Optional feature: define ATOMIC_EN to add the LL/SC link register.
//
// state | meaning
// IDLE  | sample requests, data side has priority
// DACC  | data RAM access in progress (or one-cycle failed SC)
// IACC  | instruction RAM access in progress
// HIT   | one-cycle hit pulse, RAM idle, stale request bubble
module dcache_responder #(
    parameter int LATENCY = 2
) (
    input logic              CLK,
    input logic              nRST,
    dcache_responder_if.slave bus
);

    typedef enum logic [1:0] {IDLE, DACC, IACC, HIT} state_t;

    localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

    state_t      r_state;
    logic [3:0]  r_cnt;
    logic [31:0] r_addr;
    logic [31:0] r_store;
    logic        r_is_write;
    logic        r_is_sc;
    logic        r_sc_fail;
    logic        r_ihit;
    logic        r_dhit;
    logic [31:0] r_imemload;
    logic [31:0] r_dmemload;

    logic        w_req_d;
    logic        w_access_done;
    logic        w_is_sc;
    logic        w_sc_fail_now;

    assign w_req_d       = bus.dmemREN | bus.dmemWEN;
    assign w_access_done = (r_cnt >= LAT_M1) && bus.ramready;

`ifdef ATOMIC_EN
    logic        r_link_valid;
    logic [31:0] r_link_addr;
    logic        w_is_ll;
    logic        w_link_hit;

    // REN+WEN together counts as a write, so LL needs WEN low
    assign w_is_sc       = bus.datomic & bus.dmemWEN;
    assign w_is_ll       = bus.datomic & bus.dmemREN & ~bus.dmemWEN;
    assign w_link_hit    = r_link_valid && (r_link_addr == bus.dmemaddr);
    assign w_sc_fail_now = w_is_sc & ~w_link_hit;

    // Link register: set by LL, cleared by any SC or a plain write to the linked word
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_link_valid <= 1'b0;
            r_link_addr  <= '0;
        end else if (r_state == IDLE && w_req_d) begin
            if (w_is_ll) begin
                r_link_valid <= 1'b1;
                r_link_addr  <= bus.dmemaddr;
            end else if (w_is_sc) begin
                r_link_valid <= 1'b0;
            end else if (bus.dmemWEN && w_link_hit) begin
                r_link_valid <= 1'b0;
            end
        end
    end
`else
    assign w_is_sc       = 1'b0;
    assign w_sc_fail_now = 1'b0;
`endif

    // Main sequencer: request capture, access timing, hit pulse and load data
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_addr     <= '0;
            r_store    <= '0;
            r_is_write <= 1'b0;
            r_is_sc    <= 1'b0;
            r_sc_fail  <= 1'b0;
            r_ihit     <= 1'b0;
            r_dhit     <= 1'b0;
            r_imemload <= '0;
            r_dmemload <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_cnt <= '0;
                    if (w_req_d) begin
                        r_addr     <= bus.dmemaddr;
                        r_store    <= bus.dmemstore;
                        r_is_write <= bus.dmemWEN;
                        r_is_sc    <= w_is_sc;
                        r_sc_fail  <= w_sc_fail_now;
                        r_state    <= DACC;
                    end else if (bus.imemREN) begin
                        r_addr     <= bus.imemaddr;
                        r_is_write <= 1'b0;
                        r_is_sc    <= 1'b0;
                        r_sc_fail  <= 1'b0;
                        r_state    <= IACC;
                    end
                end
                DACC: begin
                    if (r_cnt != 4'hF) r_cnt <= r_cnt + 4'd1;
                    if (r_sc_fail) begin
                        r_dmemload <= '0;
                        r_dhit     <= 1'b1;
                        r_state    <= HIT;
                    end else if (w_access_done) begin
                        if (!r_is_write) r_dmemload <= bus.ramload;
                        else if (r_is_sc) r_dmemload <= 32'd1;
                        r_dhit  <= 1'b1;
                        r_state <= HIT;
                    end
                end
                IACC: begin
                    if (r_cnt != 4'hF) r_cnt <= r_cnt + 4'd1;
                    if (w_access_done) begin
                        r_imemload <= bus.ramload;
                        r_ihit     <= 1'b1;
                        r_state    <= HIT;
                    end
                end
                HIT: begin
                    r_ihit  <= 1'b0;
                    r_dhit  <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // RAM strobes decode from state so they fall with an asynchronous reset
    assign bus.ramREN   = ((r_state == DACC) || (r_state == IACC)) && !r_is_write;
    assign bus.ramWEN   = (r_state == DACC) && r_is_write && !r_sc_fail;
    assign bus.ramaddr  = r_addr;
    assign bus.ramstore = r_store;
    assign bus.ihit     = r_ihit;
    assign bus.dhit     = r_dhit;
    assign bus.imemload = r_imemload;
    assign bus.dmemload = r_dmemload;

endmodule

// File: tb/tb_dcache_responder.sv
// tb_dcache_responder: randomized transactions against a transaction-level
// reference model (memory array, link state, expected timing from the rules).
module tb_dcache_responder;

    localparam int LAT = 2;

    logic CLK;
    logic nRST;
    int   n_cmp;
    int   n_err;
    int unsigned cyc_cnt;
    int unsigned last_hit_cyc;

    dcache_responder_if bus ();

    dcache_responder #(.LATENCY(LAT)) dut (
        .CLK  (CLK),
        .nRST (nRST),
        .bus  (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc_cnt <= cyc_cnt + 1;

    // RAM model written by the DUT, and the reference memory kept by the bench
    logic [31:0] ram_mem [logic [31:0]];
    logic [31:0] ref_mem [logic [31:0]];
    logic [31:0] ref_iload;
    logic [31:0] ref_dload;
    logic        ref_lv;
    logic [31:0] ref_la;
    logic [31:0] pool [4];

    always @(posedge CLK)
        if (bus.ramWEN && bus.ramready) ram_mem[bus.ramaddr] = bus.ramstore;

    function automatic logic [31:0] seed_val(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h5A5A5A5A;
    endfunction

    function automatic logic [31:0] ram_read(input logic [31:0] a);
        return ram_mem.exists(a) ? ram_mem[a] : seed_val(a);
    endfunction

    function automatic logic [31:0] ref_read(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : seed_val(a);
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One transaction: k_i=fetch, else data read (k_w=0) or write (k_w=1).
    // rdy[i] is ramready in the i-th access cycle (1 beyond bit 15).
    task automatic run_txn(input bit k_i, input bit k_w, input bit atom,
                           input logic [31:0] addr, input logic [31:0] data,
                           input logic [15:0] rdy, input bit keep_i, input bit both);
        bit sc, ll, fail, hit_seen, addr_checked;
        int dacc, en_exp, en_cnt, cyc;
        sc = 1'b0;
        ll = 1'b0;
`ifdef ATOMIC_EN
        sc = !k_i && k_w && atom;
        ll = !k_i && !k_w && atom;
`endif
        fail = sc && !(ref_lv && ref_la == addr);
        if (fail) begin
            dacc   = 1;
            en_exp = 0;
        end else begin
            dacc = 17;
            for (int i = LAT - 1; i < 16; i++)
                if (rdy[i] && dacc == 17) dacc = i + 1;
            en_exp = dacc;
        end

        if (k_i) begin
            bus.imemREN  = 1'b1;
            bus.imemaddr = addr;
            bus.dmemREN  = 1'b0;
            bus.dmemWEN  = 1'b0;
        end else begin
            bus.imemREN   = keep_i;
            bus.dmemREN   = !k_w || both;
            bus.dmemWEN   = k_w;
            bus.datomic   = atom;
            bus.dmemaddr  = addr;
            bus.dmemstore = data;
        end
        @(posedge CLK);
        cyc = 0;
        hit_seen = 1'b0;
        en_cnt = 0;
        addr_checked = 1'b0;
        while (!hit_seen && cyc < 40) begin
            @(negedge CLK);
            cyc++;
            if (cyc == 1) begin
                bus.imemaddr  = $urandom;
                bus.dmemaddr  = $urandom;
                bus.dmemstore = $urandom;
                bus.datomic   = 1'($urandom_range(0, 1));
            end
            if (bus.ramREN || bus.ramWEN) begin
                en_cnt++;
                if (!addr_checked) begin
                    addr_checked = 1'b1;
                    chk("ram_kind", {30'd0, bus.ramREN, bus.ramWEN}, k_w ? 32'd1 : 32'd2);
                    chk("ramaddr", bus.ramaddr, addr);
                    if (k_w) chk("ramstore", bus.ramstore, data);
                end
            end
            if (bus.ihit || bus.dhit) begin
                hit_seen = 1'b1;
                last_hit_cyc = cyc_cnt;
            end else begin
                bus.ramready = (cyc - 1 < 16) ? rdy[cyc - 1] : 1'b1;
                bus.ramload  = ram_read(bus.ramaddr);
            end
        end

        if (!hit_seen) begin
            chk("hit_timeout", 32'd0, 32'd1);
        end else begin
            if (k_i) begin
                ref_iload = ref_read(addr);
            end else if (!k_w) begin
                ref_dload = ref_read(addr);
                if (ll) begin
                    ref_lv = 1'b1;
                    ref_la = addr;
                end
            end else begin
                if (fail) ref_dload = 32'd0;
                else begin
                    ref_mem[addr] = data;
                    if (sc) ref_dload = 32'd1;
                end
                if (sc) ref_lv = 1'b0;
                else if (ref_lv && ref_la == addr) ref_lv = 1'b0;
            end
            chk("hit_cycle", 32'(cyc), 32'(dacc + 1));
            chk("en_cycles", 32'(en_cnt), 32'(en_exp));
            chk("hit_kind", {30'd0, bus.ihit, bus.dhit}, k_i ? 32'd2 : 32'd1);
            chk("imemload", bus.imemload, ref_iload);
            chk("dmemload", bus.dmemload, ref_dload);
        end
        // request held through the edge ending the hit, dropped in the bubble cycle
        @(negedge CLK);
        chk("pulse_end", {30'd0, bus.ihit, bus.dhit}, 32'd0);
        chk("bubble_en", {30'd0, bus.ramREN, bus.ramWEN}, 32'd0);
        bus.dmemREN = 1'b0;
        bus.dmemWEN = 1'b0;
        bus.datomic = 1'b0;
        bus.imemREN = keep_i;
    endtask

    task automatic reset_mid_dacc();
        int hits, ens;
        bus.dmemREN  = 1'b1;
        bus.dmemaddr = 32'h180;
        bus.ramready = 1'b1;
        @(posedge CLK);
        @(posedge CLK);
        #2 nRST = 1'b0;
        #1;
        chk("rst_en", {30'd0, bus.ramREN, bus.ramWEN}, 32'd0);
        chk("rst_hit", {30'd0, bus.ihit, bus.dhit}, 32'd0);
        chk("rst_ramaddr", bus.ramaddr, 32'd0);
        chk("rst_ramstore", bus.ramstore, 32'd0);
        chk("rst_dmemload", bus.dmemload, 32'd0);
        chk("rst_imemload", bus.imemload, 32'd0);
        ref_iload = 32'd0;
        ref_dload = 32'd0;
        ref_lv    = 1'b0;
        bus.dmemREN = 1'b0;
        @(negedge CLK);
        nRST = 1'b1;
        hits = 0;
        ens  = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge CLK);
            if (bus.ihit || bus.dhit) hits++;
            if (bus.ramREN || bus.ramWEN) ens++;
        end
        chk("post_rst_hits", 32'(hits), 32'd0);
        chk("post_rst_en", 32'(ens), 32'd0);
    endtask

    initial begin
        int unsigned t_d, r1, r2;
        logic [15:0] rdy;
        int kind;
        n_cmp = 0;
        n_err = 0;
        cyc_cnt = 0;
        last_hit_cyc = 0;
        ref_iload = 32'd0;
        ref_dload = 32'd0;
        ref_lv    = 1'b0;
        ref_la    = 32'd0;
        for (int i = 0; i < 4; i++) pool[i] = ($urandom & 32'hFFFF_FF00) | 32'(i * 4);
        nRST          = 1'b0;
        bus.imemREN   = 1'b0;
        bus.imemaddr  = 32'd0;
        bus.dmemREN   = 1'b0;
        bus.dmemWEN   = 1'b0;
        bus.datomic   = 1'b0;
        bus.dmemaddr  = 32'd0;
        bus.dmemstore = 32'd0;
        bus.ramload   = 32'd0;
        bus.ramready  = 1'b0;
        #23;
        chk("reset_hit", {30'd0, bus.ihit, bus.dhit}, 32'd0);
        chk("reset_en", {30'd0, bus.ramREN, bus.ramWEN}, 32'd0);
        chk("reset_ramaddr", bus.ramaddr, 32'd0);
        chk("reset_ramstore", bus.ramstore, 32'd0);
        chk("reset_imemload", bus.imemload, 32'd0);
        chk("reset_dmemload", bus.dmemload, 32'd0);
        @(negedge CLK);
        nRST = 1'b1;
        @(negedge CLK);

        // fetch 0x40 returning 0x8C010004 with ramready held high
        run_txn(1'b0, 1'b1, 1'b0, 32'h40, 32'h8C01_0004, 16'hFFFF, 1'b0, 1'b0);
        run_txn(1'b1, 1'b0, 1'b0, 32'h40, 32'h0, 16'hFFFF, 1'b0, 1'b0);

        // I and D raised together: D first, I follows LAT+2 cycles after dhit
        bus.imemREN = 1'b1;
        run_txn(1'b0, 1'b0, 1'b0, 32'h100, 32'h0, 16'hFFFF, 1'b1, 1'b0);
        t_d = last_hit_cyc;
        run_txn(1'b1, 1'b0, 1'b0, 32'h44, 32'h0, 16'hFFFF, 1'b0, 1'b0);
        chk("prio_gap", last_hit_cyc - t_d, 32'(LAT + 2));

        // write with ramready low for the first six access cycles
        run_txn(1'b0, 1'b1, 1'b0, 32'h200, 32'hDEAD_BEEF, 16'hFFC0, 1'b0, 1'b0);
        run_txn(1'b0, 1'b0, 1'b0, 32'h200, 32'h0, 16'hFFFF, 1'b0, 1'b0);
        // never-ready window longer than the counter range
        run_txn(1'b0, 1'b0, 1'b0, 32'h204, 32'h0, 16'h0000, 1'b0, 1'b0);

`ifdef ATOMIC_EN
        run_txn(1'b0, 1'b0, 1'b1, 32'h300, 32'h0, 16'hFFFF, 1'b0, 1'b0);
        run_txn(1'b0, 1'b1, 1'b1, 32'h300, 32'h1, 16'hFFFF, 1'b0, 1'b0);
        run_txn(1'b0, 1'b1, 1'b1, 32'h300, 32'h2, 16'hFFFF, 1'b0, 1'b0);
        run_txn(1'b0, 1'b0, 1'b1, 32'h300, 32'h0, 16'hFFFF, 1'b0, 1'b0);
        run_txn(1'b0, 1'b1, 1'b0, 32'h300, 32'h5, 16'hFFFF, 1'b0, 1'b0);
        run_txn(1'b0, 1'b1, 1'b1, 32'h300, 32'h6, 16'hFFFF, 1'b0, 1'b0);
        run_txn(1'b0, 1'b0, 1'b0, 32'h300, 32'h0, 16'hFFFF, 1'b0, 1'b0);
`else
        run_txn(1'b0, 1'b0, 1'b1, 32'h300, 32'h0, 16'hFFFF, 1'b0, 1'b0);
        run_txn(1'b0, 1'b1, 1'b1, 32'h300, 32'h77, 16'hFFFF, 1'b0, 1'b0);
        run_txn(1'b0, 1'b0, 1'b0, 32'h300, 32'h0, 16'hFFFF, 1'b0, 1'b0);
`endif

        reset_mid_dacc();
        run_txn(1'b0, 1'b0, 1'b0, 32'h180, 32'h0, 16'hFFFF, 1'b0, 1'b0);

        for (int n = 0; n < 60; n++) begin
            r1 = $urandom;
            r2 = $urandom;
            rdy = 16'(r1) | 16'(r2);
            if ($urandom_range(0, 3) == 0) rdy = 16'hFFFF;
            kind = $urandom_range(0, 2);
            run_txn(kind == 0, kind == 2, 1'($urandom_range(0, 1)),
                    pool[$urandom_range(0, 3)], $urandom, rdy, 1'b0,
                    $urandom_range(0, 3) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
